data_sram_resp: RTL and testbench
=================================

// Module: data_sram_resp
// PURPOSE
//  Responder for the core's data SRAM port: serves load/store requests issued by EX, returns read data
//  sampled by MEM in the cycle after the access completes. Backed by a word-addressed on-chip array with
//  configurable wait states; raises a stall request to the hazard/stall controller while an access is pending.
// PARAMETERS
//  ADDR_W       10  word-address width; array depth = 2**ADDR_W words of 32 bits
//  WAIT_CYCLES  2   wait states per access (0..15); 0 = single-cycle, no stall ever raised
// PORTS
//  clk              in   1   clock
//  rst              in   1   reset, synchronous, active-high
//  data_sram_en     in   1   request valid this cycle
//  data_sram_wen    in   4   byte write enables; 4'b0000 = read
//  data_sram_addr   in   32  byte address; word index = addr[ADDR_W+1:2]
//  data_sram_wdata  in   32  store data, lane i = wdata[8i+7:8i]
//  data_sram_rdata  out  32  read data, held until next completed read
//  stallreq_mem     out  1   pipeline stall request (combinational in IDLE)
//  addr_err         out  1   1-cycle pulse: completed access had addr[31:ADDR_W+2]!=0
//  rd_count         out  32  completed in-range reads, wraps at 2**32
//  wr_count         out  32  completed in-range writes, wraps at 2**32
// BEHAVIOUR
//  Reset: rdata=0, stallreq_mem=0, addr_err=0, rd_count=wr_count=0, FSM=IDLE, cnt=0. Array not cleared.
//  Reset mid-access: pending access aborted, no array write, no counter update, no addr_err.
//  FSM states IDLE, WAIT; 4-bit down-counter cnt.
//  IDLE, en=0: stallreq=0, nothing happens.
//  IDLE, en=1, WAIT_CYCLES=0: stallreq=0; access performed at this edge; stay IDLE.
//  IDLE, en=1, WAIT_CYCLES>0: stallreq=1; capture addr/wen/wdata; -> WAIT, cnt=WAIT_CYCLES-1.
//  WAIT: stallreq=(cnt!=0); cnt!=0 -> cnt-1; cnt==0 -> perform captured access at this edge, -> IDLE.
//  Timing: request first seen cycle T -> stallreq high T..T+W-1, access at end of T+W, rdata valid T+W+1.
//  Core holds inputs stable while stalled; inputs ignored in WAIT (captured copy used).
//  Request in cycle after completion is a new access (pipeline advanced) and is processed normally.
//  Access: wen!=0 -> write enabled byte lanes only, rdata unchanged; wen==0 -> rdata<=array[idx].
//  Out of range (addr[31:ADDR_W+2]!=0): no write, read returns 32'h0, addr_err pulses in T+W+1,
//  counters unchanged. addr[1:0] ignored (word access).
//  Read-after-write, back-to-back same word: read returns newly written bytes.
//  rd_count/wr_count increment by 1 on each completed in-range access, registered, wrap 32'hFFFFFFFF->0.
// TESTING
//  W=0: write 0xDEADBEEF wen=F @0x10, read @0x10 next cycle -> rdata=0xDEADBEEF one cycle later, stallreq=0.
//  W=2: read @0x20 held 3 cycles -> stallreq 1,1,0; rdata valid 4th cycle; rd_count 0->1.
//  Byte lanes: word=0x11223344, write wen=4'b0101 wdata=0xAABBCCDD -> read 0x11BB33DD.
//  Out of range: read addr=0x0001_0000 (ADDR_W=10) -> rdata=0, addr_err pulse, counters unchanged.
//  Reset asserted in WAIT of a write to 0x40 -> stallreq=0 next cycle, later read of 0x40 returns old value.
//  Counter wrap: preload/force wr_count=32'hFFFFFFFF, one write -> wr_count=0.

Source files
------------

// File: rtl/data_sram_resp_if.sv
// Data SRAM port bundle between the core (master) and the responder (slave).
interface data_sram_resp_if;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        stallreq_mem;
   logic        addr_err;
   logic [31:0] rd_count;
   logic [31:0] wr_count;

   modport master (
      output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
      input  data_sram_rdata, stallreq_mem, addr_err, rd_count, wr_count
   );

   modport slave (
      input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
      output data_sram_rdata, stallreq_mem, addr_err, rd_count, wr_count
   );
endinterface

// File: rtl/data_sram_resp.sv
// Data SRAM responder: word-addressed on-chip array with configurable wait
// states, stall request while an access is pending, and access counters.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  S_IDLE | no access pending; a request is either done now (no wait
//         | states) or captured and the FSM moves to S_WAIT
//  S_WAIT | counting down wait states; access performed when r_cnt == 0
module data_sram_resp #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   data_sram_resp_if.slave bus
);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   localparam bit         LP_ZERO_WAIT = (WAIT_CYCLES == 0);
   localparam logic [3:0] LP_CNT_INIT  = LP_ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wen;
   logic [31:0] r_rdata;
   logic [31:0] r_rd_count;
   logic [31:0] r_wr_count;
   logic        r_addr_err;

   logic        w_stall;
   logic        w_do_acc;
   logic [31:0] w_acc_addr;
   logic [31:0] w_acc_wdata;
   logic [3:0]  w_acc_wen;
   logic        w_in_range;
   logic [ADDR_W-1:0] w_idx;

   logic [31:0] r_mem [2**ADDR_W];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (bus.data_sram_en && !LP_ZERO_WAIT) w_next = S_WAIT;
         S_WAIT: if (r_cnt == 4'd0) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs of the FSM: stall request and access strobe.
   always_comb begin
      w_stall  = 1'b0;
      w_do_acc = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_stall  = bus.data_sram_en && !LP_ZERO_WAIT;
            w_do_acc = bus.data_sram_en && LP_ZERO_WAIT;
         end
         S_WAIT: begin
            w_stall  = (r_cnt != 4'd0);
            w_do_acc = (r_cnt == 4'd0);
         end
         default: ;
      endcase
   end

   // Wait-state down-counter, loaded when a request is accepted.
   always_ff @(posedge clk) begin
      if (rst)
         r_cnt <= 4'd0;
      else if (r_state == S_IDLE && bus.data_sram_en && !LP_ZERO_WAIT)
         r_cnt <= LP_CNT_INIT;
      else if (r_state == S_WAIT && r_cnt != 4'd0)
         r_cnt <= r_cnt - 4'd1;
   end

   // Capture the request so inputs are ignored while waiting.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && bus.data_sram_en) begin
         r_addr  <= bus.data_sram_addr;
         r_wen   <= bus.data_sram_wen;
         r_wdata <= bus.data_sram_wdata;
      end
   end

   // Zero-wait accesses use the live inputs; otherwise the captured copy.
   always_comb begin
      if (r_state == S_IDLE) begin
         w_acc_addr  = bus.data_sram_addr;
         w_acc_wen   = bus.data_sram_wen;
         w_acc_wdata = bus.data_sram_wdata;
      end else begin
         w_acc_addr  = r_addr;
         w_acc_wen   = r_wen;
         w_acc_wdata = r_wdata;
      end
   end

   assign w_in_range = (w_acc_addr[31:ADDR_W+2] == '0);
   assign w_idx      = w_acc_addr[ADDR_W+1:2];

   // Byte-lane array write; reset aborts a completing access.
   always_ff @(posedge clk) begin
      if (!rst && w_do_acc && w_in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (w_acc_wen[i]) r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
         end
      end
   end

   // Read data, address error pulse and access counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata    <= 32'h0;
         r_addr_err <= 1'b0;
         r_rd_count <= 32'h0;
         r_wr_count <= 32'h0;
      end else begin
         r_addr_err <= w_do_acc && !w_in_range;
         if (w_do_acc) begin
            if (w_acc_wen == 4'b0000)
               r_rdata <= w_in_range ? r_mem[w_idx] : 32'h0;
            if (w_in_range) begin
               if (w_acc_wen == 4'b0000) r_rd_count <= r_rd_count + 32'd1;
               else                      r_wr_count <= r_wr_count + 32'd1;
            end
         end
      end
   end

   assign bus.data_sram_rdata = r_rdata;
   assign bus.stallreq_mem    = w_stall;
   assign bus.addr_err        = r_addr_err;
   assign bus.rd_count        = r_rd_count;
   assign bus.wr_count        = r_wr_count;

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: randomized scoreboard on a 2-wait-state instance,
// plus directed checks on a zero-wait instance.
module tb_data_sram_resp;

   localparam int W = 2;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic [31:0] rd;
      logic [31:0] wr;
   } exp_t;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   exp_t        sb_q[$];
   logic [31:0] ref_mem [1024];
   logic [31:0] m_last_rd;
   logic [31:0] m_rd_cnt;
   logic [31:0] m_wr_cnt;

   data_sram_resp_if bus2 ();
   data_sram_resp_if bus0 ();

   data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference behaviour of one completed access, applied to the model.
   task automatic model_access(input logic [3:0] wen, input logic [31:0] addr,
                               input logic [31:0] wdata);
      exp_t e;
      int   idx;
      logic [31:0] w;
      idx = int'(addr[11:2]);
      if (addr[31:12] == 20'h0) begin
         if (wen != 4'b0000) begin
            w = ref_mem[idx];
            for (int i = 0; i < 4; i++) if (wen[i]) w[8*i +: 8] = wdata[8*i +: 8];
            ref_mem[idx] = w;
            m_wr_cnt = m_wr_cnt + 32'd1;
         end else begin
            m_last_rd = ref_mem[idx];
            m_rd_cnt  = m_rd_cnt + 32'd1;
         end
         e.err = 1'b0;
      end else begin
         if (wen == 4'b0000) m_last_rd = 32'h0;
         e.err = 1'b1;
      end
      e.rdata = m_last_rd;
      e.rd    = m_rd_cnt;
      e.wr    = m_wr_cnt;
      sb_q.push_back(e);
   endtask

   // Issue one request on the W=2 port and hold it until the stall drops.
   task automatic do_acc(input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata);
      int n;
      bit st;
      bit done;
      @(negedge clk);
      bus2.data_sram_en    = 1'b1;
      bus2.data_sram_wen   = wen;
      bus2.data_sram_addr  = addr;
      bus2.data_sram_wdata = wdata;
      n    = 0;
      done = 1'b0;
      while (!done && n < 20) begin
         #1 st = bus2.stallreq_mem;
         @(posedge clk);
         n++;
         if (!st) done = 1'b1;
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL stall_timeout: stall still high after %0d cycles", n);
      end else begin
         chk("stall_len", 32'(n), 32'(W + 1));
         model_access(wen, addr, wdata);
      end
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) begin
         @(negedge clk);
         bus2.data_sram_en = 1'b0;
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      @(negedge clk);
      bus2.data_sram_en = 1'b0;
      while (sb_q.size() != 0 && k < 10) begin
         @(negedge clk);
         k++;
      end
      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d responses never checked", sb_q.size());
         sb_q.delete();
      end
      @(negedge clk);
   endtask

   // Monitor: each completed access is checked on the falling edge after it.
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk("rdata",    bus2.data_sram_rdata, e.rdata);
         chk("addr_err", 32'(bus2.addr_err),   32'(e.err));
         chk("rd_count", bus2.rd_count,        e.rd);
         chk("wr_count", bus2.wr_count,        e.wr);
      end else if (!rst) begin
         chk("addr_err_idle", 32'(bus2.addr_err), 32'h0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [3:0]  wn;
      n_tests   = 0;
      n_fail    = 0;
      m_last_rd = 32'h0;
      m_rd_cnt  = 32'h0;
      m_wr_cnt  = 32'h0;
      rst = 1'b1;
      bus2.data_sram_en = 1'b0; bus2.data_sram_wen = 4'h0;
      bus2.data_sram_addr = 32'h0; bus2.data_sram_wdata = 32'h0;
      bus0.data_sram_en = 1'b0; bus0.data_sram_wen = 4'h0;
      bus0.data_sram_addr = 32'h0; bus0.data_sram_wdata = 32'h0;
      repeat (3) @(negedge clk);

      chk("rst_rdata",  bus2.data_sram_rdata,   32'h0);
      chk("rst_stall",  32'(bus2.stallreq_mem), 32'h0);
      chk("rst_err",    32'(bus2.addr_err),     32'h0);
      chk("rst_rd",     bus2.rd_count,          32'h0);
      chk("rst_wr",     bus2.wr_count,          32'h0);
      chk("rst0_rdata", bus0.data_sram_rdata,   32'h0);
      rst = 1'b0;

      // Zero-wait instance: write then read back-to-back.
      @(negedge clk);
      bus0.data_sram_en = 1'b1; bus0.data_sram_wen = 4'hF;
      bus0.data_sram_addr = 32'h10; bus0.data_sram_wdata = 32'hDEADBEEF;
      #1 chk("w0_stall_wr", 32'(bus0.stallreq_mem), 32'h0);
      @(negedge clk);
      bus0.data_sram_wen = 4'h0; bus0.data_sram_wdata = 32'h0;
      #1 chk("w0_stall_rd", 32'(bus0.stallreq_mem), 32'h0);
      @(negedge clk);
      bus0.data_sram_en = 1'b0;
      chk("w0_rdata", bus0.data_sram_rdata, 32'hDEADBEEF);
      chk("w0_rd",    bus0.rd_count,        32'd1);
      chk("w0_wr",    bus0.wr_count,        32'd1);

      // Fill the 32 words the random phase uses so contents are known.
      for (int i = 0; i < 32; i++) do_acc(4'hF, 32'(i * 4), $urandom);
      drain();

      do_acc(4'h0, 32'h20, 32'h0);
      do_acc(4'hF, 32'h30, 32'h11223344);
      do_acc(4'b0101, 32'h30, 32'hAABBCCDD);
      do_acc(4'h0, 32'h30, 32'h0);
      do_acc(4'h0, 32'h0001_0000, 32'h0);
      do_acc(4'hF, 32'h8000_0004, 32'h12345678);
      drain();

      for (int r = 0; r < 150; r++) begin
         a  = {20'h0, 5'h0, 5'($urandom_range(0, 31)), 2'($urandom)};
         if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
         wn = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         do_acc(wn, a, $urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drain();

      // Reset during the wait phase of a write to 0x40.
      @(negedge clk);
      bus2.data_sram_en = 1'b1; bus2.data_sram_wen = 4'hF;
      bus2.data_sram_addr = 32'h40; bus2.data_sram_wdata = ~ref_mem[16];
      @(posedge clk);
      @(negedge clk);
      bus2.data_sram_en = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rstw_stall", 32'(bus2.stallreq_mem), 32'h0);
      chk("rstw_rd",    bus2.rd_count,          32'h0);
      chk("rstw_wr",    bus2.wr_count,          32'h0);
      chk("rstw_rdata", bus2.data_sram_rdata,   32'h0);
      rst = 1'b0;
      m_last_rd = 32'h0;
      m_rd_cnt  = 32'h0;
      m_wr_cnt  = 32'h0;
      do_acc(4'h0, 32'h40, 32'h0);
      drain();

      // Write counter wrap.
      force u_dut.r_wr_count = 32'hFFFF_FFFF;
      @(negedge clk);
      release u_dut.r_wr_count;
      m_wr_cnt = 32'hFFFF_FFFF;
      do_acc(4'hF, 32'h44, 32'hCAFEF00D);
      do_acc(4'h0, 32'h44, 32'h0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
